// File: rtl/cprs_acc.sv
// Compressor-tree consumer: resolves each redundant sum/carry beat to binary,
// accumulates a frame with saturation, and hands out one total per frame.
module cprs_acc #(
  parameter int W     = 8,
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_sum,
  input  logic [W-1:0]     in_carry,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic [LEN_W-1:0] out_beats
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A valid producer holds its payload stable until that transfer; ready is
  // never derived from the same side's valid.

  logic             s1_val;
  logic             s1_last;
  logic [ACC_W-1:0] s1_sum;

  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [LEN_W-1:0] cnt;

  logic             adv;
  logic             take;
  logic [W:0]       resolved;
  logic [ACC_W:0]   new_wide;
  logic [ACC_W-1:0] new_sat;
  logic             new_ovf;
  logic [LEN_W-1:0] cnt_next;

  always_comb begin
    // Only a last beat needs the result register, so only it can stall.
    adv      = s1_val && !(s1_last && out_valid && !out_ready);
    in_ready = !rst && (!s1_val || adv);
    take     = in_valid && in_ready;
    resolved = {1'b0, in_sum} + {1'b0, in_carry};
    new_wide = {1'b0, acc} + {1'b0, s1_sum};
    new_ovf  = new_wide[ACC_W];
    new_sat  = new_ovf ? '1 : new_wide[ACC_W-1:0];
    cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val  <= 1'b0;
      s1_last <= 1'b0;
      s1_sum  <= '0;
    end else if (take) begin
      s1_val  <= 1'b1;
      s1_last <= in_last;
      s1_sum  <= ACC_W'(resolved);
    end else if (adv) begin
      s1_val  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (adv) begin
      if (s1_last) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else begin
        acc <= new_sat;
        ovf <= ovf | new_ovf;
        cnt <= cnt_next;
      end
    end
  end

  // A new result may land in the same cycle the old one is taken: no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (adv && s1_last) begin
        out_valid <= 1'b1;
        out_acc   <= new_sat;
        out_ovf   <= ovf | new_ovf;
        out_beats <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_cprs_acc.sv
// Bench for cprs_acc: directed scenarios plus random frames, all results
// checked against a frame-level arithmetic model through one check task.
module tb_cprs_acc;
  localparam int W     = 8;
  localparam int ACC_W = 16;
  localparam int LEN_W = 8;
  localparam int EXP_W = 1 + LEN_W + ACC_W;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
  localparam int     CNT_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_sum = '0;
  logic [W-1:0]     in_carry = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [LEN_W-1:0] out_beats;

  int n_vec = 0;
  int n_err = 0;
  bit rand_or = 1'b0;

  always #5 clk = ~clk;

  cprs_acc #(.W(W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf), .out_beats(out_beats)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: frame total as an unbounded integer, clipped at the end.
  logic [EXP_W-1:0] exp_q[$];
  longint frame_total = 0;
  int     frame_beats = 0;

  function automatic logic [EXP_W-1:0] make_exp(input longint total, input int beats);
    logic [ACC_W-1:0] a;
    logic [LEN_W-1:0] b;
    logic             o;
    o = (total > ACC_MAX);
    a = o ? ACC_W'(ACC_MAX) : ACC_W'(total);
    b = (beats > CNT_MAX) ? LEN_W'(CNT_MAX) : LEN_W'(beats);
    return {o, b, a};
  endfunction

  logic             stall_prev = 1'b0;
  logic [EXP_W-1:0] held = '0;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst) begin
      exp_q.delete();
      frame_total = 0;
      frame_beats = 0;
      stall_prev  = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_ovf, out_beats, out_acc}), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_acc", 32'(out_acc), 32'(e[ACC_W-1:0]));
          check("out_beats", 32'(out_beats), 32'(e[ACC_W+LEN_W-1:ACC_W]));
          check("out_ovf", 32'(out_ovf), 32'(e[EXP_W-1]));
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_ovf, out_beats, out_acc};
      if (in_valid && in_ready) begin
        frame_total += longint'(in_sum) + longint'(in_carry);
        frame_beats++;
        if (in_last) begin
          exp_q.push_back(make_exp(frame_total, frame_beats));
          frame_total = 0;
          frame_beats = 0;
        end
      end
    end
  end

  // Random backpressure, active only in the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input int s, input int c, input bit last, output int waits);
    in_valid = 1'b1;
    in_sum   = W'(s);
    in_carry = W'(c);
    in_last  = last;
    waits    = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits >= 200) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int len;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_acc", 32'(out_acc), 32'd0);
    check("reset_out_ovf", 32'(out_ovf), 32'd0);
    check("reset_out_beats", 32'(out_beats), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 3-beat frame and output latency
    send_beat(3, 5, 0, w);
    send_beat(10, 20, 0, w);
    send_beat(0, 255, 1, w);
    @(negedge clk);
    check("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_rise", 32'(out_valid), 32'd1);
    check("t1_acc", 32'(out_acc), 32'd293);
    check("t1_beats", 32'(out_beats), 32'd3);
    @(posedge clk); #1;
    idle(3);

    // back-to-back frames with no idle gap
    send_beat(255, 255, 1, w); check("no_gap0", 32'(w), 32'd0);
    send_beat(1, 1, 0, w);     check("no_gap1", 32'(w), 32'd0);
    send_beat(2, 2, 1, w);     check("no_gap2", 32'(w), 32'd0);
    idle(4);

    // result held under backpressure while the next last beat stalls
    out_ready = 1'b0;
    send_beat(7, 0, 1, w);
    fork
      begin
        send_beat(1, 0, 0, w); check("stall_first_accept", 32'(w), 32'd0);
        send_beat(1, 0, 1, w);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_acc", 32'(out_acc), 32'd7);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(4);

    // long frame saturating accumulator and beat count, then a clean frame
    for (int i = 0; i < 300; i++) send_beat(255, 255, i == 299, w);
    send_beat(1, 1, 1, w);
    idle(4);

    // reset discards a frame in progress
    send_beat(100, 0, 0, w);
    send_beat(100, 0, 0, w);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send_beat(4, 4, 1, w);
    idle(4);

    // random frames with random gaps and backpressure
    rand_or = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        send_beat($urandom_range(0, 255), $urandom_range(0, 255), b == len - 1, w);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    rand_or = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    idle(20);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
